// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures register-file writebacks into a FIFO and drains them
// through a valid/ready stream. The producer never stalls; writes that find the
// FIFO full are dropped and counted.
module wb_trace_fifo #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter bit          DROP_R0 = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          wb_we,
    input  logic [4:0]    wb_addr,
    input  logic [31:0]   wb_data,
    input  logic          clr_ovf,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_addr,
    output logic [31:0]   out_data,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [15:0]   drop_cnt
);

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned CNT_W   = 16;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        wr_ptr_n;
    logic [AW:0]        rd_ptr_n;
    logic [AW:0]        level_n;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               drop;
    logic               full;
    logic [ENTRY_W-1:0] wb_entry;
    logic [ENTRY_W-1:0] head_n;
    logic               overflow_n;
    logic [CNT_W-1:0]   drop_cnt_n;

    // Occupancy follows directly from the wrap-bit pointers.
    assign level = wr_ptr - rd_ptr;

    // Push/pop qualification, next pointers, next head entry and drop accounting.
    always_comb begin
        wb_entry   = {wb_addr, wb_data};
        push_req   = wb_we & ~(DROP_R0 && (wb_addr == ADDR_W'(0)));
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = out_valid & out_ready;
        push       = push_req & (~full | pop);
        drop       = push_req & ~push;
        wr_ptr_n   = wr_ptr + (AW+1)'(push);
        rd_ptr_n   = rd_ptr + (AW+1)'(pop);
        level_n    = wr_ptr_n - rd_ptr_n;

        // The new head is the entry being written this edge when it lands at the read slot.
        if (push && (rd_ptr_n == wr_ptr)) begin
            head_n = wb_entry;
        end else begin
            head_n = mem[rd_ptr_n[AW-1:0]];
        end

        // A drop in the same cycle as a clear wins: the count restarts at one.
        overflow_n = overflow;
        drop_cnt_n = drop_cnt;
        if (drop) begin
            overflow_n = 1'b1;
            if (clr_ovf) begin
                drop_cnt_n = CNT_W'(1);
            end else if (drop_cnt != {CNT_W{1'b1}}) begin
                drop_cnt_n = drop_cnt + CNT_W'(1);
            end
        end else if (clr_ovf) begin
            overflow_n = 1'b0;
            drop_cnt_n = '0;
        end
    end

    // Entry storage; contents need no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wb_entry;
        end
    end

    // Pointers, registered head outputs and overflow state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            out_valid <= (level_n != '0);
            if (level_n != '0) begin
                out_addr <= head_n[ENTRY_W-1:DATA_W];
                out_data <= head_n[DATA_W-1:0];
            end
            overflow  <= overflow_n;
            drop_cnt  <= drop_cnt_n;
        end
    end

endmodule
